// File: rtl/ar_cmd_queue_pkg.sv
// Shared widths and AXI burst encodings for the AR command queue.
package ar_cmd_queue_pkg;

  localparam int unsigned ADD_ID_WIDTH = 4;
  localparam int unsigned ADD_WIDTH    = 32;
  localparam int unsigned BURST_LEN    = 4;
  localparam int unsigned BURST_SIZE   = 3;
  localparam int unsigned BURST_TYPE   = 2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

endpackage

// File: rtl/ar_cmd_queue_fifo.sv
// Generic synchronous FIFO (module sync_fifo); head word is always visible on rdata_c.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_nxt_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_c     = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/ar_cmd_queue.sv
// AXI AR command queue: buffers up to DEPTH read commands for the read-data module.
// Optional burst legality flag (err_out) enabled by AR_CMD_QUEUE_BURST_CHECK_EN.
module ar_cmd_queue #(
  parameter int unsigned ADD_ID_WIDTH = ar_cmd_queue_pkg::ADD_ID_WIDTH,
  parameter int unsigned ADD_WIDTH    = ar_cmd_queue_pkg::ADD_WIDTH,
  parameter int unsigned BURST_LEN    = ar_cmd_queue_pkg::BURST_LEN,
  parameter int unsigned BURST_SIZE   = ar_cmd_queue_pkg::BURST_SIZE,
  parameter int unsigned BURST_TYPE   = ar_cmd_queue_pkg::BURST_TYPE,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADD_ID_WIDTH-1:0]      arid,
  input  logic [ADD_WIDTH-1:0]         araddr,
  input  logic [BURST_LEN-1:0]         arlen,
  input  logic [BURST_SIZE-1:0]        arsize,
  input  logic [BURST_TYPE-1:0]        arburst,
  input  logic [1:0]                   arlock,
  input  logic [3:0]                   arcache,
  input  logic [2:0]                   arprot,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ADD_WIDTH-1:0]         address_out,
  output logic [ADD_ID_WIDTH-1:0]      id_out,
  output logic [BURST_LEN-1:0]         len_out,
  output logic [BURST_SIZE-1:0]        size_out,
  output logic [BURST_TYPE-1:0]        burst_out,
  output logic                         mod2_valid_out,
  input  logic                         mod2_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
`ifdef AR_CMD_QUEUE_BURST_CHECK_EN
  ,
  output logic                         err_out
`endif
);

  import ar_cmd_queue_pkg::*;

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PAYLD_W = ADD_ID_WIDTH + ADD_WIDTH + BURST_LEN + BURST_SIZE + BURST_TYPE;
`ifdef AR_CMD_QUEUE_BURST_CHECK_EN
  localparam int unsigned CMD_W = PAYLD_W + 1;
`else
  localparam int unsigned CMD_W = PAYLD_W;
`endif

  logic [CMD_W-1:0] wdata_c, head_c;
  logic [CNT_W-1:0] count_c, count_nxt_c;
  logic             full_c, empty_c;
  logic             push_c, pop_c;
  logic             arready_q, arready_d;

  assign push_c = arvalid && arready_q;
  assign pop_c  = mod2_ready_in && !empty_c;

`ifdef AR_CMD_QUEUE_BURST_CHECK_EN
  // Reserved burst type, or WRAP whose beat count is not 2/4/8/16.
  logic err_c;
  assign err_c = (arburst == BURST_TYPE'(BURST_RSVD)) ||
                 ((arburst == BURST_TYPE'(BURST_WRAP)) &&
                  !((arlen == BURST_LEN'(1)) || (arlen == BURST_LEN'(3)) ||
                    (arlen == BURST_LEN'(7)) || (arlen == BURST_LEN'(15))));
  assign wdata_c = {arid, araddr, arlen, arsize, arburst, err_c};
  assign {id_out, address_out, len_out, size_out, burst_out, err_out} = head_c;
`else
  assign wdata_c = {arid, araddr, arlen, arsize, arburst};
  assign {id_out, address_out, len_out, size_out, burst_out} = head_c;
`endif

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .wdata_i     (wdata_c),
    .rdata_c     (head_c),
    .full_o      (full_c),
    .empty_o     (empty_c),
    .count_o     (count_c),
    .count_nxt_c (count_nxt_c)
  );

  // arready looks one cycle ahead so a pop at full reopens the slot next cycle.
  assign arready_d = (count_nxt_c != CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) arready_q <= 1'b0;
    else       arready_q <= arready_d;
  end

  assign arready        = arready_q;
  assign mod2_valid_out = !empty_c;
  assign count_out      = count_c;

  logic unused_sideband;
  assign unused_sideband = ^{arlock, arcache, arprot, full_c, BURST_FIXED, BURST_INCR};

endmodule

// File: tb/tb_ar_cmd_queue.sv
// Directed self-checking bench for ar_cmd_queue (DEPTH=4, default widths).
module tb_ar_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] address_out;
  logic [3:0]  id_out;
  logic [3:0]  len_out;
  logic [2:0]  size_out;
  logic [1:0]  burst_out;
  logic        mod2_valid_out;
  logic        mod2_ready_in;
  logic [2:0]  count_out;
`ifdef AR_CMD_QUEUE_BURST_CHECK_EN
  logic        err_out;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  ar_cmd_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .arid           (arid),
    .araddr         (araddr),
    .arlen          (arlen),
    .arsize         (arsize),
    .arburst        (arburst),
    .arlock         (arlock),
    .arcache        (arcache),
    .arprot         (arprot),
    .arvalid        (arvalid),
    .arready        (arready),
    .address_out    (address_out),
    .id_out         (id_out),
    .len_out        (len_out),
    .size_out       (size_out),
    .burst_out      (burst_out),
    .mod2_valid_out (mod2_valid_out),
    .mod2_ready_in  (mod2_ready_in),
    .count_out      (count_out)
`ifdef AR_CMD_QUEUE_BURST_CHECK_EN
    ,
    .err_out        (err_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (arready !== 1'b0) begin tests_failed++; $display("FAIL reset_arready got %0h want 0", arready); end
    tests_run++;
    if (mod2_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0h want 0", mod2_valid_out); end
    tests_run++;
    if (count_out !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count_out); end
    tests_run++;
    if (address_out !== 32'h0 || id_out !== 4'h0 || len_out !== 4'h0)
      begin tests_failed++; $display("FAIL reset_payload got addr %0h id %0h len %0h want 0", address_out, id_out, len_out); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (arready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_arready got %0h want 1", arready); end
    tests_run++;
    if (mod2_valid_out !== 1'b0) begin tests_failed++; $display("FAIL idle_valid got %0h want 0", mod2_valid_out); end
  endtask

  task automatic test_single;
    mod2_ready_in = 1'b1;
    arvalid = 1'b1; araddr = 32'h1000; arid = 4'd3; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01;
    tick();
    arvalid = 1'b0; araddr = 32'hDEAD_BEEF;
    tests_run++;
    if (mod2_valid_out !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %0h want 1", mod2_valid_out); end
    tests_run++;
    if (address_out !== 32'h1000 || id_out !== 4'd3 || len_out !== 4'd7 || size_out !== 3'd2 || burst_out !== 2'b01)
      begin tests_failed++; $display("FAIL single_payload got addr %0h id %0d len %0d size %0d burst %0d want 1000 3 7 2 1",
                                     address_out, id_out, len_out, size_out, burst_out); end
    tests_run++;
    if (count_out !== 3'd1) begin tests_failed++; $display("FAIL single_count got %0d want 1", count_out); end
    tick();
    tests_run++;
    if (count_out !== 3'd0 || mod2_valid_out !== 1'b0)
      begin tests_failed++; $display("FAIL single_drain got count %0d valid %0h want 0 0", count_out, mod2_valid_out); end
  endtask

  task automatic test_fill;
    mod2_ready_in = 1'b0;
    arburst = 2'b01; arlen = 4'd0;
    for (int i = 0; i < 4; i++) begin
      arvalid = 1'b1; araddr = 32'((i + 1) * 16); arid = 4'(i);
      tick();
    end
    tests_run++;
    if (count_out !== 3'd4) begin tests_failed++; $display("FAIL fill_count got %0d want 4", count_out); end
    tests_run++;
    if (arready !== 1'b0) begin tests_failed++; $display("FAIL fill_arready got %0h want 0", arready); end
    araddr = 32'h50; arid = 4'd9;
    tick();
    arvalid = 1'b0;
    tests_run++;
    if (count_out !== 3'd4) begin tests_failed++; $display("FAIL fill_overflow_count got %0d want 4", count_out); end
    tests_run++;
    if (address_out !== 32'h10) begin tests_failed++; $display("FAIL fill_head_stable got %0h want 10", address_out); end
    mod2_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mod2_valid_out !== 1'b1 || address_out !== 32'((i + 1) * 16) || id_out !== 4'(i))
        begin tests_failed++; $display("FAIL fill_order[%0d] got valid %0h addr %0h id %0d want 1 %0h %0d",
                                       i, mod2_valid_out, address_out, id_out, (i + 1) * 16, i); end
      tick();
      if (i == 0) begin
        tests_run++;
        if (arready !== 1'b1) begin tests_failed++; $display("FAIL fill_arready_reopen got %0h want 1", arready); end
      end
    end
    tests_run++;
    if (count_out !== 3'd0 || mod2_valid_out !== 1'b0)
      begin tests_failed++; $display("FAIL fill_empty got count %0d valid %0h want 0 0", count_out, mod2_valid_out); end
  endtask

  task automatic test_back_to_back;
    mod2_ready_in = 1'b0;
    arburst = 2'b01; arlen = 4'd1;
    for (int i = 0; i < 2; i++) begin
      arvalid = 1'b1; araddr = 32'h100 + 32'(i);
      tick();
    end
    mod2_ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      araddr = 32'h102 + 32'(k);
      tests_run++;
      if (address_out !== 32'h100 + 32'(k))
        begin tests_failed++; $display("FAIL b2b_head[%0d] got %0h want %0h", k, address_out, 32'h100 + 32'(k)); end
      tick();
      tests_run++;
      if (count_out !== 3'd2 || arready !== 1'b1)
        begin tests_failed++; $display("FAIL b2b_count[%0d] got count %0d arready %0h want 2 1", k, count_out, arready); end
    end
    arvalid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      tests_run++;
      if (address_out !== 32'h100 + 32'(k) || mod2_valid_out !== 1'b1)
        begin tests_failed++; $display("FAIL b2b_drain[%0d] got %0h valid %0h want %0h 1", k, address_out, mod2_valid_out, 32'h100 + 32'(k)); end
      tick();
    end
    tests_run++;
    if (count_out !== 3'd0) begin tests_failed++; $display("FAIL b2b_final_count got %0d want 0", count_out); end
  endtask

  task automatic test_reset_mid;
    mod2_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arvalid = 1'b1; araddr = 32'hA0 + 32'(i);
      tick();
    end
    arvalid = 1'b0;
    tests_run++;
    if (count_out !== 3'd3) begin tests_failed++; $display("FAIL mid_pre_count got %0d want 3", count_out); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mod2_ready_in = 1'b1;
    tests_run++;
    if (count_out !== 3'd0 || mod2_valid_out !== 1'b0 || address_out !== 32'h0)
      begin tests_failed++; $display("FAIL mid_reset got count %0d valid %0h addr %0h want 0 0 0", count_out, mod2_valid_out, address_out); end
    tick();
    tests_run++;
    if (mod2_valid_out !== 1'b0 || arready !== 1'b1)
      begin tests_failed++; $display("FAIL mid_idle got valid %0h arready %0h want 0 1", mod2_valid_out, arready); end
    mod2_ready_in = 1'b0;
    arvalid = 1'b1; araddr = 32'hB0;
    tick();
    arvalid = 1'b0;
    tests_run++;
    if (address_out !== 32'hB0 || count_out !== 3'd1)
      begin tests_failed++; $display("FAIL mid_new_entry got addr %0h count %0d want b0 1", address_out, count_out); end
    mod2_ready_in = 1'b1;
    tick();
    tests_run++;
    if (count_out !== 3'd0) begin tests_failed++; $display("FAIL mid_drain got %0d want 0", count_out); end
  endtask

`ifdef AR_CMD_QUEUE_BURST_CHECK_EN
  task automatic test_burst_check;
    logic [1:0] bt [3];
    logic [3:0] ln [3];
    logic       ex [3];
    bt[0] = 2'b10; ln[0] = 4'd5; ex[0] = 1'b1;
    bt[1] = 2'b10; ln[1] = 4'd3; ex[1] = 1'b0;
    bt[2] = 2'b11; ln[2] = 4'd0; ex[2] = 1'b1;
    mod2_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arvalid = 1'b1; arburst = bt[i]; arlen = ln[i]; araddr = 32'hC0 + 32'(i);
      tick();
    end
    arvalid = 1'b0;
    mod2_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (err_out !== ex[i] || address_out !== 32'hC0 + 32'(i))
        begin tests_failed++; $display("FAIL burst_err[%0d] got err %0h addr %0h want %0h %0h", i, err_out, address_out, ex[i], 32'hC0 + 32'(i)); end
      tick();
    end
  endtask
`endif

  initial begin
    reset = 1'b1; arvalid = 1'b0; mod2_ready_in = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = 2'b01; arcache = 4'hF; arprot = 3'h7;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_reset_mid();
`ifdef AR_CMD_QUEUE_BURST_CHECK_EN
    test_burst_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ar_cmd_queue.md
Name: ar_cmd_queue

Overview:
Parametrised successor to the AXI read-address acceptor in the memory slave. It accepts AR-channel commands from the master and buffers up to DEPTH outstanding commands in a FIFO, where the previous block held only one. It presents the oldest command to the read-data module (mod2) over a valid/ready handshake, so the master can issue back-to-back reads while a data burst is still in progress.

Parameters:
ADD_ID_WIDTH, 4, width of arid/id_out
ADD_WIDTH, 32, width of araddr/address_out
BURST_LEN, 4, width of arlen/len_out
BURST_SIZE, 3, width of arsize/size_out
BURST_TYPE, 2, width of arburst/burst_out
DEPTH, 4, number of command entries; power of 2, at least 2

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
arid  in  ADD_ID_WIDTH  AR transaction ID
araddr  in  ADD_WIDTH  AR start address
arlen  in  BURST_LEN  beats minus 1
arsize  in  BURST_SIZE  bytes per beat, log2 encoded
arburst  in  BURST_TYPE  burst type (FIXED/INCR/WRAP)
arlock  in  2  accepted, not stored
arcache  in  4  accepted, not stored
arprot  in  3  accepted, not stored
arvalid  in  1  master command valid
arready  out  1  slave can accept a command
address_out  out  ADD_WIDTH  head-entry address
id_out  out  ADD_ID_WIDTH  head-entry ID
len_out  out  BURST_LEN  head-entry length
size_out  out  BURST_SIZE  head-entry size
burst_out  out  BURST_TYPE  head-entry burst type
mod2_valid_out  out  1  head entry valid
mod2_ready_in  in  1  mod2 consumes the head entry
count_out  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (synchronous, priority over everything):
  - wr_ptr, rd_ptr and count cleared to 0.
  - arready, mod2_valid_out and count_out are 0.
  - All payload outputs are 0.
  - Any in-flight or stored commands are discarded.
- arready is registered and equals (count_next != DEPTH). It reads 0 during reset and 1 in the first cycle after reset is released.
- Push: arvalid && arready. Store {arid, araddr, arlen, arsize, arburst} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Pop: mod2_valid_out && mod2_ready_in. rd_ptr increments and wraps modulo DEPTH.
- mod2_valid_out = (count != 0).
- Payload outputs always show the entry at rd_ptr. They are held stable while mod2_valid_out=1 and mod2_ready_in=0.
- Latency: push to mod2_valid_out is 1 cycle, because there is no combinational bypass. Push-to-head is 1 cycle when the queue is empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any occupancy from 1 to DEPTH-1.
- Full (count==DEPTH): arready=0. A pop in that cycle raises arready in the next cycle; push never overwrites.
- Empty (count==0): mod2_ready_in is ignored and no pop occurs.
- Ordering: strict FIFO; IDs do not reorder commands.
- count_out = count. It is an unsigned count of width $clog2(DEPTH+1) and never exceeds DEPTH.
- Master AR payload is sampled only on push. arlock, arcache and arprot are ignored.

Optional Feature:
Macro AR_CMD_QUEUE_BURST_CHECK_EN.
- Defined:
  - Adds port err_out (out, 1) alongside the head entry, plus an extra stored bit per entry.
  - The bit is set at push when arburst==2'b11 (reserved), or when arburst==2'b10 (WRAP) with arlen not in {1,3,7,15}.
  - The command is still queued normally.
  - err_out resets to 0.
- Undefined: no err_out port and no extra storage; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - Width constants ADD_ID_WIDTH, ADD_WIDTH, BURST_LEN, BURST_SIZE, BURST_TYPE.
  - Burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
- One natural sub-module: sync_fifo, a generic synchronous FIFO parametrised by WIDTH and DEPTH, with outputs full, empty and count. ar_cmd_queue packs and unpacks the command word around it.

Test Plan:
1. Reset, then idle: arready=0 during reset, 1 one cycle after; mod2_valid_out=0; count_out=0.
2. Single command, araddr=0x1000, arid=3, arlen=7, arburst=INCR, mod2_ready_in=1 → next cycle mod2_valid_out=1, address_out=0x1000, id_out=3, len_out=7; popped that cycle, count_out returns to 0.
3. Fill with DEPTH=4 and mod2_ready_in=0: push addresses 0x10, 0x20, 0x30, 0x40 → count_out=4, arready=0, a fifth arvalid is not accepted, head=0x10 stable; release ready → outputs 0x10, 0x20, 0x30, 0x40 in order and arready returns to 1.
4. Simultaneous push and pop at count=2 for 10 cycles → count_out stays 2 and pointers wrap cleanly with no data loss or duplication.
5. Reset mid-operation at count=3 → next cycle count_out=0, mod2_valid_out=0, and the old entries never reappear.
6. With AR_CMD_QUEUE_BURST_CHECK_EN: push WRAP with arlen=5 → err_out=1 at head; push WRAP with arlen=3 → err_out=0; push arburst=2'b11 → err_out=1.
